seven_seg_scan_driver: RTL and testbench

Time-multiplexes four hex digits onto a shared 4-digit common-anode seven-segment display. A prescaler steps through digits 0..3 and inserts a blanking dead-time between digits to suppress ghosting. The block drives the active-low anode strobes AN[3:0] and the active-low segment/DP lines. New display contents are double-buffered and take effect only at a frame boundary, so a value never tears mid-frame. It sits between game/score logic and the board's display pins.

---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/hex_to_seg7.sv | 15 +
 rtl/seven_seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
//   scan_state_t : scan FSM states (dark gap before a digit, digit lit)
//   disp_buf_t   : one display buffer (hex nibbles, enables, decimal points)
//   SEG_BLANK    : active-low segment pattern with every segment off
//   AN_OFF       : active-low anode pattern with every digit off
//   HEX_SEG      : active-low {g,f,e,d,c,b,a} pattern per hex value
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [15:0] data;  // [3:0] = digit 0 ... [15:12] = digit 3
    logic [3:0]  en;    // 1 = digit may light during its slot
    logic [3:0]  dp;    // 1 = decimal point lit
  } disp_buf_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder (active-low outputs).
//   nibble : input  [3:0] hex value to display
//   seg    : output [6:0] segments {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot is BLANK_CYCLES dark cycles followed by PRESCALE lit
// cycles; a frame is four slots. Display contents are double-buffered:
// Update captures the inputs into a staging buffer, and the staging buffer
// is copied into the active buffer only on the last lit cycle of digit 3,
// so a frame never shows a mix of old and new data.
//
// Handshake: Update is a one-cycle strobe with no back-pressure; every
// strobe overwrites staging (last one wins). UpdateAck pulses for one cycle
// right after the frame boundary at which staging became visible. An Update
// sampled in the boundary cycle itself waits for the next boundary.
//
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   DigitData    : four hex nibbles, [3:0] = digit 0
//   DigitEnable  : per-digit enable, 0 = digit dark in its slot
//   DpIn         : per-digit decimal point request, 1 = lit
//   Update       : capture strobe for the three inputs above
//   UpdateAck    : staging-to-active transfer pulse
//   DigitSelect  : digit currently scanned
//   AN, SEG, DP  : active-low anodes, segments {g,f,e,d,c,b,a}, decimal point
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] DigitData,
  input  logic [3:0]  DigitEnable,
  input  logic [3:0]  DpIn,
  input  logic        Update,
  output logic        UpdateAck,
  output logic [1:0]  DigitSelect,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel, sel_n;
  logic             frame_end;
  logic             transfer;
  logic             pending;
  disp_buf_t        staging, active, active_n;
  logic [3:0]       nibble_n;
  logic [6:0]       seg_dec;
  logic [3:0]       an_n;
  logic [6:0]       seg_n;
  logic             dp_n;

  assign DigitSelect = sel;

  // Scan sequencing. With BLANK_CYCLES=0 the dark phase is only ever the
  // single post-reset cycle; after that the digits advance ON to ON.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    sel_n     = sel;
    frame_end = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ON;
          cnt_n   = '0;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          cnt_n     = '0;
          sel_n     = sel + 2'd1;
          frame_end = (sel == 2'd3);
          state_n   = (BLANK_CYCLES == 0) ? ON : BLANK;
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // Only a request pending before the boundary cycle is transferred.
  assign transfer = frame_end & pending;
  assign active_n = transfer ? staging : active;

  // Outputs are decoded from next-cycle state and the next active buffer so
  // that AN, SEG and DP all register together on the same edge.
  assign nibble_n = active_n.data[{sel_n, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble_n),
    .seg    (seg_dec)
  );

  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if (state_n == ON) begin
      seg_n = seg_dec;
      dp_n  = ~active_n.dp[sel_n];
      if (active_n.en[sel_n]) begin
        an_n[sel_n] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= BLANK;
      cnt       <= '0;
      sel       <= 2'd0;
      staging   <= '0;
      active    <= '0;
      pending   <= 1'b0;
      UpdateAck <= 1'b0;
      AN        <= AN_OFF;
      SEG       <= SEG_BLANK;
      DP        <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      active    <= active_n;
      UpdateAck <= transfer;
      AN        <= an_n;
      SEG       <= seg_n;
      DP        <= dp_n;
      if (Update) begin
        staging <= '{data: DigitData, en: DigitEnable, dp: DpIn};
        pending <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver. Instance a uses PRESCALE=4,
// BLANK_CYCLES=2 (slot 6 cycles, frame 24); instance b uses PRESCALE=1,
// BLANK_CYCLES=0. Every Update pushes its expected acknowledge cycle and
// buffer contents into a per-instance queue; each cycle the bench pops the
// entry due at that cycle and compares every output against the display
// expected from the slot timing and the currently visible buffer.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] HEX_TB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a, rst_b;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] data_a, data_b;
  logic [3:0]  en_a, en_b, dpi_a, dpi_b;
  logic        upd_a, upd_b;
  logic        ack_a, ack_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  seven_seg_scan_driver #(.PRESCALE(4), .BLANK_CYCLES(2)) dut_a (
    .Clk(clk), .Reset_n(rst_a), .DigitData(data_a), .DigitEnable(en_a),
    .DpIn(dpi_a), .Update(upd_a), .UpdateAck(ack_a), .DigitSelect(sel_a),
    .AN(an_a), .SEG(seg_a), .DP(dp_a)
  );

  seven_seg_scan_driver #(.PRESCALE(1), .BLANK_CYCLES(0)) dut_b (
    .Clk(clk), .Reset_n(rst_b), .DigitData(data_b), .DigitEnable(en_b),
    .DpIn(dpi_b), .Update(upd_b), .UpdateAck(ack_b), .DigitSelect(sel_b),
    .AN(an_b), .SEG(seg_b), .DP(dp_b)
  );

  // ---------------- scoreboard ----------------
  // entry = {ack cycle[31:0], data[15:0], en[3:0], dp[3:0]}
  logic [55:0] exp_q_a[$];
  logic [55:0] exp_q_b[$];
  logic [23:0] vis_a, vis_b;   // buffer the display should currently show
  int ka, kb;                  // cycles since reset release
  bit run_a, run_b;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {an, seg, dp} expected for digit s of buffer b
  function automatic logic [11:0] disp_exp(input logic [23:0] b, input int s, input logic lit);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    logic [3:0] nib;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (lit) begin
      nib   = b[8 + 4*s +: 4];
      seg_e = HEX_TB[nib];
      dp_e  = ~b[s];
      if (b[4 + s]) an_e[s] = 1'b0;
    end
    return {an_e, seg_e, dp_e};
  endfunction

  task automatic check_outputs(input string pfx, input int k, input logic ack_e, input int s,
                               input logic [11:0] d, input logic ack_o, input logic [1:0] sel_o,
                               input logic [3:0] an_o, input logic [6:0] seg_o, input logic dp_o);
    check($sformatf("%s_ack@%0d", pfx, k), 32'(ack_o), 32'(ack_e));
    check($sformatf("%s_sel@%0d", pfx, k), 32'(sel_o), 32'(s));
    check($sformatf("%s_an@%0d", pfx, k), 32'(an_o), 32'(d[11:8]));
    check($sformatf("%s_seg@%0d", pfx, k), 32'(seg_o), 32'(d[7:1]));
    check($sformatf("%s_dp@%0d", pfx, k), 32'(dp_o), 32'(d[0]));
  endtask

  // slot = 2 dark + 4 lit cycles; boundaries at multiples of 24
  task automatic chk_a();
    logic [55:0] e;
    logic ack_e;
    int s;
    ack_e = 1'b0;
    if (exp_q_a.size() > 0 && exp_q_a[0][55:24] == 32'(ka)) begin
      e = exp_q_a.pop_front();
      vis_a = e[23:0];
      ack_e = 1'b1;
    end
    s = (ka / 6) % 4;
    check_outputs("a", ka, ack_e, s, disp_exp(vis_a, s, (ka % 6) >= 2),
                  ack_a, sel_a, an_a, seg_a, dp_a);
  endtask

  // one dark cycle after reset, then one lit cycle per digit
  task automatic chk_b();
    logic [55:0] e;
    logic ack_e;
    int s;
    ack_e = 1'b0;
    if (exp_q_b.size() > 0 && exp_q_b[0][55:24] == 32'(kb)) begin
      e = exp_q_b.pop_front();
      vis_b = e[23:0];
      ack_e = 1'b1;
    end
    s = (kb == 0) ? 0 : (kb - 1) % 4;
    check_outputs("b", kb, ack_e, s, disp_exp(vis_b, s, kb != 0),
                  ack_b, sel_b, an_b, seg_b, dp_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (run_a) begin ka++; chk_a(); end
    if (run_b) begin kb++; chk_b(); end
  endtask

  task automatic run_a_to(input int n);
    while (ka < n) tick();
  endtask

  task automatic run_b_to(input int n);
    while (kb < n) tick();
  endtask

  task automatic push_exp(inout logic [55:0] q[$], input int b, input logic [15:0] d,
                          input logic [3:0] en, input logic [3:0] dp);
    logic [55:0] ent;
    ent = {32'(b), d, en, dp};
    if (q.size() > 0 && q[$][55:24] == 32'(b)) q[$] = ent;  // last one wins
    else q.push_back(ent);
  endtask

  task automatic update_a(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
    int e;
    data_a = d; en_a = en; dpi_a = dp; upd_a = 1'b1;
    e = ka + 1;                       // edge at which Update is sampled
    push_exp(exp_q_a, (e / 24 + 1) * 24, d, en, dp);
    tick();
    upd_a = 1'b0;
  endtask

  task automatic update_b(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
    int e;
    data_b = d; en_b = en; dpi_b = dp; upd_b = 1'b1;
    e = kb + 1;
    push_exp(exp_q_b, ((e - 1) / 4 + 1) * 4 + 1, d, en, dp);
    tick();
    upd_b = 1'b0;
  endtask

  task automatic check_reset(input string pfx, input logic ack_o, input logic [1:0] sel_o,
                             input logic [3:0] an_o, input logic [6:0] seg_o, input logic dp_o);
    check({pfx, "_ack"}, 32'(ack_o), 32'd0);
    check({pfx, "_sel"}, 32'(sel_o), 32'd0);
    check({pfx, "_an"},  32'(an_o),  32'hF);
    check({pfx, "_seg"}, 32'(seg_o), 32'h7F);
    check({pfx, "_dp"},  32'(dp_o),  32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    data_a = '0; en_a = '0; dpi_a = '0; upd_a = 1'b0;
    data_b = '0; en_b = '0; dpi_b = '0; upd_b = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    ka = 0; kb = 0; vis_a = '0; vis_b = '0;

    // reset values while held
    repeat (3) @(posedge clk);
    #1;
    check_reset("a_rst", ack_a, sel_a, an_a, seg_a, dp_a);
    check_reset("b_rst", ack_b, sel_b, an_b, seg_b, dp_b);

    // instance a: release, empty buffer keeps every anode off
    rst_a = 1'b1;
    run_a = 1'b1;
    chk_a();
    run_a_to(4);
    update_a(16'hF8A0, 4'b1111, 4'b0100);   // shown from cycle 24
    run_a_to(29);
    update_a(16'h1111, 4'b1111, 4'b0000);   // superseded
    run_a_to(34);
    update_a(16'h2222, 4'b1111, 4'b0000);   // shown from cycle 48
    run_a_to(71);
    update_a(16'h3C5E, 4'b1111, 4'b1010);   // sampled in boundary cycle -> 96
    run_a_to(99);
    update_a(16'h9876, 4'b0101, 4'b0011);   // digits 1 and 3 dark
    run_a_to(150);
    run_a = 1'b0;
    check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);

    // instance b: no dark gap, one cycle per digit
    rst_b = 1'b1;
    run_b = 1'b1;
    chk_b();
    update_b(16'h4321, 4'b1111, 4'b0001);   // shown from cycle 5
    run_b_to(8);
    update_b(16'hABCD, 4'b1111, 4'b0000);   // boundary cycle -> 13
    run_b_to(10);
    run_b = 1'b0;

    // asynchronous reset mid-frame with an update pending
    #2;
    rst_b = 1'b0;
    #1;
    check_reset("b_midrst", ack_b, sel_b, an_b, seg_b, dp_b);
    exp_q_b.delete();
    vis_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    kb = 0;
    run_b = 1'b1;
    chk_b();
    run_b_to(20);
    run_b = 1'b0;
    check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
